uart_rx_line: RTL and testbench
===============================

# uart_rx_line

Synthesizable, parametrised UART receiver with an integrated line buffer. It replaces the bench-only serial model on the board-facing RX pin. It oversamples the serial line and assembles characters of configurable width. Each character is appended to a single line buffer until a carriage return commits the line to the consumer. Line feeds are discarded.

## Interface
Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz
- BAUD, 115200, serial bit rate
- OVERSAMPLE, 16, ticks per bit; even, ≥4
- DATA_BITS, 8, character width, 5..8
- DEPTH, 16, line buffer capacity in characters, ≥2
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only with UART_RX_PARITY_EN

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input; idles high
- byte_valid  out  1  one-cycle pulse: character accepted
- byte_data  out  DATA_BITS  last accepted character; held until the next accept
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch
- overflow  out  1  one-cycle pulse: character dropped
- line_valid  out  1  a committed line is available
- line_len  out  $clog2(DEPTH+1)  characters in the committed or partial line
- rd_addr  in  $clog2(DEPTH)  buffer read index
- rd_data  out  DATA_BITS  buffer[rd_addr], registered
- line_ack  in  1  consumer releases the line; sampled only while line_valid=1

## Operation
- rx passes through a 2-flop synchronizer before any use.
- Tick generator: a counter divides clk by DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) and emits a one-clk tick. DIV=1 means a tick every cycle. The counter runs freely while the receiver is in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on a synchronized falling edge. The tick counter and sample counter are cleared at this point.
  - START: at OVERSAMPLE/2 ticks, rx=0 →DATA. rx=1 →IDLE (glitch; no outputs).
  - DATA: samples every OVERSAMPLE ticks, DATA_BITS samples, LSB first into a shift register. Afterwards →PARITY if parity is compiled in, else →STOP.
  - PARITY: one sample, checked against the data.
  - STOP: one sample, then →IDLE.
- Stop sample handling:
  - Stop=0: frame_err pulses, the character is discarded, and no buffer action occurs.
  - Stop=1 with a parity mismatch: parity_err pulses and the character is discarded.
  - Otherwise: the character is accepted.
- Accepted character handling, in order:
  - LF (0x0A): byte_valid pulses; nothing is written to the buffer.
  - CR (0x0D) while line_valid=0: byte_valid pulses, line_valid←1, and line_len freezes. An empty line (len 0) is legal.
  - CR while line_valid=1: byte_valid pulses and overflow pulses; the CR is dropped.
  - Other character while line_valid=1 or line_len=DEPTH: byte_valid pulses and overflow pulses; the character is dropped.
  - Other character otherwise: buffer[line_len]←char, line_len+1.
- line_ack while line_valid=1: line_valid←0 and line_len←0 on the next edge. line_ack while line_valid=0 is ignored.
- Simultaneous ack and character accept: the ack takes effect first. The character is then processed against the empty state: written at index 0 with len=1, or committed as an empty line if it is a CR.
- rd_addr ≥ line_len returns stale buffer contents; this is not an error.

## Timing
- Reset values: FSM=IDLE, all counters 0, line_len=0, rd_data=0, byte_data=0, and all pulse outputs, line_valid and the synchronizer flops 0 except synchronizer state=1. Buffer contents are undefined.
- Reset mid-frame: the FSM returns to IDLE and the partial character and any partial or committed line are lost.
- Latency from rx synchronizer output to the decision: stop-bit centre sample plus 1 clk.
  - byte_valid, frame_err, parity_err, overflow, the buffer write, line_len and line_valid all update on the same edge.
- rd_data latency is 1 clk after rd_addr.
- Back-to-back frames: the FSM re-enters IDLE at the stop-bit centre, so a start edge half a bit later is caught.
- Tolerance: correct reception with up to ±3% baud mismatch at OVERSAMPLE=16.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the PARITY state exists; frame = start, DATA_BITS, parity, stop. PARITY_ODD selects the sense; a mismatch discards the character with a parity_err pulse.
  - Undefined: there is no PARITY state, parity_err is tied 0, and PARITY_ODD is ignored.

## Test plan
Common configuration: CLK_HZ=1843200, BAUD=115200, OVERSAMPLE=16 (bit = 16 clk), DEPTH=4, DATA_BITS=8, parity disabled unless stated.
- Send "AB\r" → byte_valid ×3, line_valid=1, line_len=2. rd_addr 0/1 → rd_data 0x41/0x42 one clk later. Assert line_ack → line_valid=0, line_len=0.
- Send "\n\r" on an empty line → two byte_valid pulses, no writes, line_valid=1, line_len=0.
- Send "ABCDE\r" → the 5th character drops with overflow=1 and line_len=4. The CR commits, and buffer = "ABCD".
- Frame 0x55 with stop bit forced low → frame_err pulse, no byte_valid, line_len unchanged. A 4-clk low glitch on rx → no outputs and FSM back in IDLE.
- Assert line_ack on the exact cycle byte_valid fires for 'Z' while the line "X" is committed → line_valid=0, line_len=1, buffer[0]=0x5A.
- With UART_RX_PARITY_EN and PARITY_ODD=1: 0x41 with parity bit 1 is accepted. 0x41 with parity bit 0 → parity_err pulse and the character is discarded. Reset asserted mid-DATA → all outputs return to their reset values, and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_line.sv
// rtl/uart_rx_line.sv - oversampling UART receiver feeding a CR-terminated line buffer
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits;
// PARITY_ODD selects odd (1) or even (0) sense).
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          asynchronous serial input, idles high
//   byte_valid  1-clk pulse, a character was accepted
//   byte_data   last accepted character
//   frame_err   1-clk pulse, stop bit sampled low
//   parity_err  1-clk pulse, parity mismatch (0 without UART_RX_PARITY_EN)
//   overflow    1-clk pulse, character dropped
//   line_valid  a committed line is waiting for the consumer
//   line_len    characters in the committed or partial line
//   rd_addr     buffer read index
//   rd_data     buffer[rd_addr], one clk after rd_addr
//   line_ack    consumer releases the committed line
module uart_rx_line #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int DEPTH      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic                         byte_valid,
  output logic [DATA_BITS-1:0]         byte_data,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overflow,
  output logic                         line_valid,
  output logic [$clog2(DEPTH+1)-1:0]   line_len,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_BITS-1:0]         rd_data,
  input  logic                         line_ack
);

  localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int AW      = $clog2(DEPTH);

  localparam logic [DW-1:0]        DIV_M1   = DW'(DIV - 1);
  localparam logic [OW-1:0]        HALF_M1  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0]        FULL_M1  = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0]        FULL_LEN = LW'(DEPTH);
  localparam logic [DATA_BITS-1:0] CH_LF    = DATA_BITS'(8'h0A);
  localparam logic [DATA_BITS-1:0] CH_CR    = DATA_BITS'(8'h0D);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state;
  logic                 rx_meta, rx_s, rx_d;
  logic [DW-1:0]        tick_cnt;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] mem [2**AW];
  logic                 bad_par;

  logic tick, fall, stop_smp, accept, is_lf, is_cr;
  logic ack_now, base_valid, wr_en, commit, ovf;
  logic [LW-1:0] base_len;

  assign tick     = (tick_cnt == DIV_M1);
  assign fall     = rx_d & ~rx_s;
  assign stop_smp = (state == S_STOP) && tick && (os_cnt == FULL_M1);
  assign accept   = stop_smp & rx_s & ~bad_par;
  assign is_lf    = (shreg == CH_LF);
  assign is_cr    = (shreg == CH_CR);

  // An ack in the same cycle as a decision is applied first, so the
  // character is judged against an empty, uncommitted line.
  assign ack_now    = line_valid & line_ack;
  assign base_valid = line_valid & ~line_ack;
  assign base_len   = ack_now ? '0 : line_len;

  assign wr_en  = accept & ~is_lf & ~is_cr & ~base_valid & (base_len != FULL_LEN);
  assign commit = accept & is_cr & ~base_valid;
  assign ovf    = accept & ((is_cr & base_valid) |
                            (~is_lf & ~is_cr & (base_valid | (base_len == FULL_LEN))));

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign bad_par = par_bad;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign bad_par           = 1'b0;
  assign parity_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      tick_cnt   <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      line_valid <= 1'b0;
      line_len   <= '0;
      rd_data    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_d       <= rx_s;
      byte_valid <= accept;
      frame_err  <= stop_smp & ~rx_s;
      overflow   <= ovf;
      if (accept) byte_data <= shreg;
      line_valid <= commit | base_valid;
      line_len   <= wr_en ? base_len + 1'b1 : base_len;
      rd_data    <= mem[rd_addr];
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_err <= stop_smp & rx_s & par_bad;
`endif
      case (state)
        S_IDLE: begin
          if (fall) begin
            // Restart the bit timing from the detected start edge.
            state    <= S_START;
            tick_cnt <= '0;
            os_cnt   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            if (os_cnt == HALF_M1) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? S_IDLE : S_DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (os_cnt == FULL_M1) begin
              os_cnt <= '0;
              shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (os_cnt == FULL_M1) begin
              os_cnt  <= '0;
              par_bad <= ((^shreg) ^ rx_s) != (PARITY_ODD != 0);
              state   <= S_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          // Leaving at the stop-bit centre lets a back-to-back start edge be seen.
          if (tick) begin
            if (os_cnt == FULL_M1) begin
              os_cnt <= '0;
              state  <= S_IDLE;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Buffer storage is not reset; contents beyond line_len are stale by design.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[base_len[AW-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx_line.sv
// tb/tb_uart_rx_line.sv - self-checking bench for uart_rx_line
module tb_uart_rx_line;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam logic PODD = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          line_ack = 1'b0;
  logic [1:0]    rd_addr = '0;
  logic          byte_valid, frame_err, parity_err, overflow, line_valid;
  logic [DB-1:0] byte_data, rd_data;
  logic [2:0]    line_len;

  uart_rx_line #(
    .CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16),
    .DATA_BITS(DB), .DEPTH(DEPTH), .PARITY_ODD(1)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
    .line_valid(line_valid), .line_len(line_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .line_ack(line_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int nbv = 0, nfe = 0, npe = 0, nov = 0, last_bv_cyc = 0;
  logic [7:0] last_byte = '0;
  int dbv, dfe, dpe, dov;

  always @(negedge clk) begin
    if (byte_valid) begin nbv++; last_bv_cyc = cyc; last_byte = byte_data; end
    if (frame_err)  nfe++;
    if (parity_err) npe++;
    if (overflow)   nov++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PODD;
  endfunction

  task automatic bit_out(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    bit_out(1'b0, 16);
    for (int i = 0; i < 8; i++) bit_out(d[i], 16);
`ifdef UART_RX_PARITY_EN
    bit_out(par, 16);
`endif
    bit_out(stop, 16);
    bit_out(1'b1, 6);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic stop, input logic par);
    int b0, f0, p0, o0;
    b0 = nbv; f0 = nfe; p0 = npe; o0 = nov;
    send_frame(d, stop, par);
    dbv = nbv - b0; dfe = nfe - f0; dpe = npe - p0; dov = nov - o0;
  endtask

  task automatic read_chk(input string name, input int idx, input logic [7:0] exp);
    rd_addr = idx[1:0];
    @(posedge clk);
    @(negedge clk);
    check(name, rd_data, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack;
    line_ack = 1'b1;
    @(posedge clk);
    #1;
    line_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        stop;
    int          bv;
    int          fe;
    int          ov;
    logic        lv;
    int          len;
    logic [31:0] bufx;
    logic        ack;
  } vec_t;

  vec_t tv[16];
  logic [7:0] mq[$];
  logic       mv;
  int         lat, t0;

  initial begin
    tv[0]  = '{8'h41, 1'b1, 1, 0, 0, 1'b0, 1, 32'h0, 1'b0};
    tv[1]  = '{8'h42, 1'b1, 1, 0, 0, 1'b0, 2, 32'h0, 1'b0};
    tv[2]  = '{8'h0D, 1'b1, 1, 0, 0, 1'b1, 2, 32'h00004241, 1'b1};
    tv[3]  = '{8'h0A, 1'b1, 1, 0, 0, 1'b0, 0, 32'h0, 1'b0};
    tv[4]  = '{8'h0D, 1'b1, 1, 0, 0, 1'b1, 0, 32'h0, 1'b1};
    tv[5]  = '{8'h41, 1'b1, 1, 0, 0, 1'b0, 1, 32'h0, 1'b0};
    tv[6]  = '{8'h42, 1'b1, 1, 0, 0, 1'b0, 2, 32'h0, 1'b0};
    tv[7]  = '{8'h43, 1'b1, 1, 0, 0, 1'b0, 3, 32'h0, 1'b0};
    tv[8]  = '{8'h44, 1'b1, 1, 0, 0, 1'b0, 4, 32'h0, 1'b0};
    tv[9]  = '{8'h45, 1'b1, 1, 0, 1, 1'b0, 4, 32'h0, 1'b0};
    tv[10] = '{8'h0D, 1'b1, 1, 0, 0, 1'b1, 4, 32'h44434241, 1'b1};
    tv[11] = '{8'h55, 1'b0, 0, 1, 0, 1'b0, 0, 32'h0, 1'b0};
    tv[12] = '{8'h0D, 1'b1, 1, 0, 0, 1'b1, 0, 32'h0, 1'b0};
    tv[13] = '{8'h0D, 1'b1, 1, 0, 1, 1'b1, 0, 32'h0, 1'b1};
    tv[14] = '{8'h58, 1'b1, 1, 0, 0, 1'b0, 1, 32'h0, 1'b0};
    tv[15] = '{8'h0D, 1'b1, 1, 0, 0, 1'b1, 1, 32'h00000058, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_valid", byte_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_line_len", line_len, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_byte_data", byte_data, 0);
    rst = 1'b0;
    bit_out(1'b1, 5);

    lat = 0;
    for (int k = 0; k < 16; k++) begin
      t0 = cyc;
      run_frame(tv[k].d, tv[k].stop, good_par(tv[k].d));
      if (k == 0) lat = last_bv_cyc - t0;
      check($sformatf("vec%0d_bv", k), dbv, tv[k].bv);
      check($sformatf("vec%0d_fe", k), dfe, tv[k].fe);
      check($sformatf("vec%0d_ov", k), dov, tv[k].ov);
      check($sformatf("vec%0d_lv", k), line_valid, tv[k].lv);
      check($sformatf("vec%0d_len", k), line_len, tv[k].len);
      if (tv[k].bv != 0) check($sformatf("vec%0d_byte", k), last_byte, tv[k].d);
      if (tv[k].lv)
        for (int j = 0; j < tv[k].len; j++)
          read_chk($sformatf("vec%0d_buf%0d", k, j), j, tv[k].bufx[8*j +: 8]);
      if (tv[k].ack) begin
        do_ack();
        check($sformatf("vec%0d_ack_lv", k), line_valid, 0);
        check($sformatf("vec%0d_ack_len", k), line_len, 0);
      end
    end

    // Ack coincident with the 'Z' accept while "X" is committed
    t0 = cyc;
    begin
      int b0;
      b0 = nbv;
      fork
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        begin
          repeat (lat - 1) @(posedge clk);
          #1 line_ack = 1'b1;
          @(posedge clk);
          #1 line_ack = 1'b0;
        end
      join
      check("ackz_bv", nbv - b0, 1);
    end
    check("ackz_align", last_bv_cyc - t0, lat);
    check("ackz_byte", last_byte, 8'h5A);
    check("ackz_lv", line_valid, 0);
    check("ackz_len", line_len, 1);
    read_chk("ackz_buf0", 0, 8'h5A);

    // Short low glitch must be rejected, then a clean frame still received
    begin
      int b0, f0, o0;
      b0 = nbv; f0 = nfe; o0 = nov;
      bit_out(1'b0, 4);
      bit_out(1'b1, 40);
      check("glitch_bv", nbv - b0, 0);
      check("glitch_fe", nfe - f0, 0);
      check("glitch_ov", nov - o0, 0);
      check("glitch_len", line_len, 1);
    end
    run_frame(8'h47, 1'b1, good_par(8'h47));
    check("post_glitch_bv", dbv, 1);
    check("post_glitch_byte", last_byte, 8'h47);
    check("post_glitch_len", line_len, 2);

`ifdef UART_RX_PARITY_EN
    run_frame(8'h41, 1'b1, 1'b1);
    check("par_ok_bv", dbv, 1);
    check("par_ok_pe", dpe, 0);
    check("par_ok_len", line_len, 3);
    run_frame(8'h41, 1'b1, 1'b0);
    check("par_bad_bv", dbv, 0);
    check("par_bad_pe", dpe, 1);
    check("par_bad_len", line_len, 3);
`endif

    // Reset asserted in the middle of the data bits
    bit_out(1'b0, 16);
    bit_out(1'b1, 16);
    bit_out(1'b0, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_byte_valid", byte_valid, 0);
    check("midrst_line_valid", line_valid, 0);
    check("midrst_line_len", line_len, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_byte_data", byte_data, 0);
    check("midrst_frame_err", frame_err, 0);
    rx = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bit_out(1'b1, 20);
    run_frame(8'h4B, 1'b1, good_par(8'h4B));
    check("after_rst_bv", dbv, 1);
    check("after_rst_fe", dfe, 0);
    check("after_rst_byte", last_byte, 8'h4B);
    check("after_rst_len", line_len, 1);
    check("after_rst_lv", line_valid, 0);
    read_chk("after_rst_buf0", 0, 8'h4B);

    // Randomized traffic against the line model
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bit_out(1'b1, 4);
    mq.delete();
    mv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic       stop, par;
      int         r, ebv, efe, epe, eov;
      r    = $urandom_range(0, 11);
      d    = 8'h61 + 8'($urandom_range(0, 25));
      if (r == 0) d = 8'h0A;
      if (r == 1 || r == 2) d = 8'h0D;
      stop = (r == 3) ? 1'b0 : 1'b1;
      par  = good_par(d) ^ (r == 4);
      ebv = 0; efe = 0; epe = 0; eov = 0;
      if (!stop) efe = 1;
`ifdef UART_RX_PARITY_EN
      else if (((^d) ^ par) != PODD) epe = 1;
`endif
      else begin
        ebv = 1;
        if (d == 8'h0A) ;
        else if (d == 8'h0D) begin
          if (mv) eov = 1; else mv = 1'b1;
        end else if (mv || mq.size() == DEPTH) eov = 1;
        else mq.push_back(d);
      end
      run_frame(d, stop, par);
      check($sformatf("rnd%0d_bv", k), dbv, ebv);
      check($sformatf("rnd%0d_fe", k), dfe, efe);
      check($sformatf("rnd%0d_pe", k), dpe, epe);
      check($sformatf("rnd%0d_ov", k), dov, eov);
      if (ebv != 0) check($sformatf("rnd%0d_byte", k), last_byte, d);
      check($sformatf("rnd%0d_lv", k), line_valid, mv);
      check($sformatf("rnd%0d_len", k), line_len, mq.size());
      if (mv && $urandom_range(0, 1) == 1) begin
        for (int j = 0; j < mq.size(); j++)
          read_chk($sformatf("rnd%0d_buf%0d", k, j), j, mq[j]);
        do_ack();
        mv = 1'b0;
        mq.delete();
        check($sformatf("rnd%0d_ack_lv", k), line_valid, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
